uart_xcvr_cfg: RTL and testbench
================================

Name: uart_xcvr_cfg

Overview:
Runtime-configurable full-duplex UART transceiver. It is the successor to the fixed 8N1 UART interface.
- Adds a programmable baud divisor, 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, and parity/framing/overrun error reporting.
- Uses valid/ready handshakes on both directions.
- Sits between the pins and the system-side rx/tx queues; the queues are instantiated outside this block.

Parameters:
DIV_WIDTH, 16, width of the clocks-per-bit divisor.
SYNC_STAGES, 2, number of uart_rx_i synchroniser flops (2..3).

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous reset, active-low
cfg_div_i  input  DIV_WIDTH  clocks per bit; values <4 are treated as 4
cfg_data_bits_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity_i  input  2  00=none, 01=even, 10=odd, 11=none
cfg_stop2_i  input  1  1=two stop bits (TX only; RX checks first stop)
uart_rx_i  input  1  serial in
uart_cts_o  output  1  1=may send to us
uart_tx_o  output  1  serial out
uart_rts_i  input  1  1=peer ready; tie high if unused
rx_valid_o  output  1  received word held
rx_ready_i  input  1  consumer accepts
rx_data_o  output  8  received word, LSB-aligned, unused MSBs zero
rx_perr_o  output  1  parity error for held word
rx_ferr_o  output  1  framing error for held word
rx_ovr_o  output  1  1-clk pulse: word dropped (overrun)
tx_valid_i  input  1  word offered
tx_ready_o  output  1  transmitter idle, can accept
tx_data_i  input  8  word to send (upper unused bits ignored)

Behaviour:
- Reset values: uart_tx_o=1, uart_cts_o=1, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, rx_perr_o=0, rx_ferr_o=0, rx_ovr_o=0. All FSMs go to IDLE; counters clear. The synchroniser resets to 1s.
- Config latching: cfg_* are latched per direction at frame start. Changing cfg_* mid-frame has no effect on the current frame.
- half = div>>1, where div is the clamped divisor.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on a synchronised falling edge; the bit counter is cleared.
  - In START, a sample at count==half that reads 1 is a false start: go back to IDLE with no output.
  - Each bit is sampled at count==half; the counter wraps at div-1.
  - DATA shifts in LSB first for N bits. It then goes to PARITY if parity is enabled, otherwise to STOP.
  - Parity check: perr=1 if the XOR of data bits and the parity bit ≠ 0 (even) or ≠ 1 (odd).
  - STOP is sampled at mid-bit; 0 → ferr=1. The FSM returns to IDLE at that same sample point, allowing back-to-back frames.
- RX holding register:
  - The frame completes at the stop sample. On the next clock, rx_valid_o=1 and data/perr/ferr are loaded.
  - These outputs stay stable until the cycle where rx_valid_o & rx_ready_i; rx_valid_o drops on the following clock.
  - Simultaneous completion and handshake in the same cycle: the new word is loaded, and rx_valid_o stays 1.
  - Completion while holding and not handshaking: rx_ovr_o pulses for 1 clk, the new word is discarded, and the held word is unchanged.
- uart_cts_o = ~rx_valid_o, registered.
- TX FSM states: IDLE, WAIT_RTS, START, DATA, PARITY, STOP1, STOP2.
  - A word is accepted when tx_valid_i & tx_ready_o. tx_ready_o falls on the next clock. Data and config are latched.
  - IDLE→WAIT_RTS. WAIT_RTS→START on the first cycle uart_rts_i=1; uart_tx_o=0 from the following clock.
  - Each bit lasts exactly div clocks.
  - The parity bit is the XOR of the N data bits (even) or its inverse (odd).
  - STOP2 occurs only if stop2. After the final stop bit's div clocks, the FSM returns to IDLE and tx_ready_o=1 on the same clock.
  - uart_rts_i is sampled only in WAIT_RTS. Deasserting it mid-frame does not abort the frame.
- Reset mid-frame: everything returns to reset values immediately.
  - uart_tx_o goes 1, which may truncate the frame on the line.
  - RX re-hunts for a start bit after reset release.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each RX bit is the 2-of-3 majority of samples at count half-1, half and half+1. The decision is made at half+1, and all timing references shift by one clock.
- Undefined: single sample at half. No extra flops.

Test Plan:
- Loopback (uart_tx_o→uart_rx_i), div=16, 8N1, send 0xA5. Line shows 0,1,0,1,0,0,1,0,1,1, each 16 clks. rx_data_o=0xA5, perr=ferr=0. tx_ready_o is low for 160 clks.
- div=16, 7E1, send 0x35. Parity bit=0 and the frame is 10 bits. Drive the same frame with the parity bit flipped → rx_data_o=0x35, rx_perr_o=1.
- Drive a frame with stop bit=0 → rx_ferr_o=1. Drive a 0.25-bit low glitch → no rx_valid_o (false start).
- rx_ready_i=0, receive 0x11 then 0x22. rx_valid_o stays 1 with 0x11 and uart_cts_o=0. rx_ovr_o pulses once at the second frame's completion, and 0x22 is lost.
- uart_rts_i=0, tx_valid_i with 0x5A. Word accepted, line stays 1. Raise uart_rts_i → start bit on the next clock. With stop2=1, the line stays high 32 clks before tx_ready_o=1.
- Assert rst_ni low in the middle of TX data bit 3 → uart_tx_o=1 and tx_ready_o=1 immediately. After release, the next word transmits correctly.

Source files
------------

// File: rtl/uart_xcvr_cfg.sv
// rtl/uart_xcvr_cfg.sv - configurable full-duplex UART transceiver; UART_RX_MAJORITY_EN enables 2-of-3 RX sampling
module uart_xcvr_cfg #(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [1:0]           cfg_data_bits_i,
    input  logic [1:0]           cfg_parity_i,
    input  logic                 cfg_stop2_i,
    input  logic                 uart_rx_i,
    output logic                 uart_cts_o,
    output logic                 uart_tx_o,
    input  logic                 uart_rts_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_perr_o,
    output logic                 rx_ferr_o,
    output logic                 rx_ovr_o,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [7:0]           tx_data_i
);

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT_RTS, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_e;

    logic [DIV_WIDTH-1:0] div_clamped;
    assign div_clamped = (cfg_div_i < DIV_MIN) ? DIV_MIN : cfg_div_i;

    // ---------------- RX ----------------
    logic [SYNC_STAGES-1:0] rx_sync_q;
    logic                   rx_s, rx_prev_q, rx_bit;
    logic [DIV_WIDTH-1:0]   rx_samp_pt;

    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]           rx_idx_q, rx_idx_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic                 rx_pacc_q, rx_pacc_d, rx_pbad_q, rx_pbad_d;
    logic [1:0]           rx_nb_q, rx_nb_d, rx_par_q, rx_par_d;
    logic                 rx_samp, rx_wrap, rx_done;

    logic                 rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d, cts_q;
    logic [7:0]           rx_data_q, rx_data_d;

    assign rx_s = rx_sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic rx_prev2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_prev2_q <= 1'b1;
        else         rx_prev2_q <= rx_prev_q;
    end
    assign rx_bit     = (rx_prev2_q & rx_prev_q) | (rx_prev2_q & rx_s) | (rx_prev_q & rx_s);
    assign rx_samp_pt = (rx_div_q >> 1) + ONE;
`else
    assign rx_bit     = rx_s;
    assign rx_samp_pt = rx_div_q >> 1;
`endif

    assign rx_samp = (rx_cnt_q == rx_samp_pt);
    assign rx_wrap = (rx_cnt_q == rx_div_q - ONE);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_pacc_d  = rx_pacc_q;
        rx_pbad_d  = rx_pbad_q;
        rx_nb_d    = rx_nb_q;
        rx_par_d   = rx_par_q;
        rx_done    = 1'b0;
        if (rx_state_q != RX_IDLE) rx_cnt_d = rx_wrap ? '0 : rx_cnt_q + ONE;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_shift_d = '0;
                    rx_pacc_d  = 1'b0;
                    rx_pbad_d  = 1'b0;
                    rx_div_d   = div_clamped;
                    rx_nb_d    = cfg_data_bits_i;
                    rx_par_d   = cfg_parity_i;
                end
            end
            RX_START: begin
                if (rx_samp && rx_bit) rx_state_d = RX_IDLE;
                else if (rx_wrap)      rx_state_d = RX_DATA;
            end
            RX_DATA: begin
                if (rx_samp) begin
                    rx_shift_d[rx_idx_q] = rx_bit;
                    rx_pacc_d            = rx_pacc_q ^ rx_bit;
                end
                if (rx_wrap) begin
                    if (rx_idx_q == ({1'b0, rx_nb_q} + 3'd4)) begin
                        rx_idx_d   = '0;
                        rx_state_d = (rx_par_q == 2'b01 || rx_par_q == 2'b10) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_samp) rx_pbad_d = (rx_pacc_q ^ rx_bit) != (rx_par_q == 2'b10);
                if (rx_wrap) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                // leave at the stop sample so a back-to-back start edge is not missed
                if (rx_samp) begin
                    rx_state_d = RX_IDLE;
                    rx_done    = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_ovr_d   = 1'b0;
        if (rx_done) begin
            if (rx_valid_q && !rx_ready_i) begin
                rx_ovr_d = 1'b1;
            end else begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                rx_perr_d  = rx_pbad_q;
                rx_ferr_d  = ~rx_bit;
            end
        end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
    end

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [7:0]           tx_data_q, tx_data_d, tx_mask;
    logic [1:0]           tx_nb_q, tx_nb_d, tx_par_q, tx_par_d;
    logic                 tx_stop2_q, tx_stop2_d, tx_line_q, tx_line_d, tx_wrap, tx_par_bit;

    assign tx_wrap    = (tx_cnt_q == tx_div_q - ONE);
    assign tx_mask    = 8'hFF >> (2'd3 - tx_nb_q);
    assign tx_par_bit = (^(tx_data_q & tx_mask)) ^ (tx_par_q == 2'b10);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_nb_d    = tx_nb_q;
        tx_par_d   = tx_par_q;
        tx_stop2_d = tx_stop2_q;
        if (tx_state_q != TX_IDLE && tx_state_q != TX_WAIT_RTS)
            tx_cnt_d = tx_wrap ? '0 : tx_cnt_q + ONE;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid_i) begin
                    tx_state_d = TX_WAIT_RTS;
                    tx_data_d  = tx_data_i;
                    tx_div_d   = div_clamped;
                    tx_nb_d    = cfg_data_bits_i;
                    tx_par_d   = cfg_parity_i;
                    tx_stop2_d = cfg_stop2_i;
                end
            end
            TX_WAIT_RTS: begin
                if (uart_rts_i) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                end
            end
            TX_START: begin
                if (tx_wrap) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_wrap) begin
                    if (tx_idx_q == ({1'b0, tx_nb_q} + 3'd4))
                        tx_state_d = (tx_par_q == 2'b01 || tx_par_q == 2'b10) ? TX_PARITY : TX_STOP1;
                    else
                        tx_idx_d = tx_idx_q + 3'd1;
                end
            end
            TX_PARITY: if (tx_wrap) tx_state_d = TX_STOP1;
            TX_STOP1:  if (tx_wrap) tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
            TX_STOP2:  if (tx_wrap) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
        // line level registered from the next state so the pin never glitches
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_data_q[tx_idx_d];
            TX_PARITY: tx_line_d = tx_par_bit;
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q  <= '1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_MIN;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_pacc_q  <= 1'b0;
            rx_pbad_q  <= 1'b0;
            rx_nb_q    <= 2'b11;
            rx_par_q   <= 2'b00;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            cts_q      <= 1'b1;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_MIN;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_nb_q    <= 2'b11;
            tx_par_q   <= 2'b00;
            tx_stop2_q <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], uart_rx_i};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_pacc_q  <= rx_pacc_d;
            rx_pbad_q  <= rx_pbad_d;
            rx_nb_q    <= rx_nb_d;
            rx_par_q   <= rx_par_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
            cts_q      <= ~rx_valid_q;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_nb_q    <= tx_nb_d;
            tx_par_q   <= tx_par_d;
            tx_stop2_q <= tx_stop2_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign rx_perr_o  = rx_perr_q;
    assign rx_ferr_o  = rx_ferr_q;
    assign rx_ovr_o   = rx_ovr_q;
    assign uart_cts_o = cts_q;
    assign uart_tx_o  = tx_line_q;
    assign tx_ready_o = (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_uart_xcvr_cfg.sv
// tb/tb_uart_xcvr_cfg.sv - table-driven and directed bench for uart_xcvr_cfg
module tb_uart_xcvr_cfg;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_db, cfg_par;
    logic        cfg_stop2;
    logic        rx_line, rx_drv, loop_en;
    logic        uart_cts, uart_tx, uart_rts;
    logic        rx_valid, rx_ready, rx_perr, rx_ferr, rx_ovr;
    logic [7:0]  rx_data, tx_data;
    logic        tx_valid, tx_ready;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ovr_seen = 0;

    always #5 clk = ~clk;
    assign rx_line = loop_en ? uart_tx : rx_drv;

    uart_xcvr_cfg #(.DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_div_i(cfg_div), .cfg_data_bits_i(cfg_db), .cfg_parity_i(cfg_par), .cfg_stop2_i(cfg_stop2),
        .uart_rx_i(rx_line), .uart_cts_o(uart_cts), .uart_tx_o(uart_tx), .uart_rts_i(uart_rts),
        .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
        .rx_perr_o(rx_perr), .rx_ferr_o(rx_ferr), .rx_ovr_o(rx_ovr),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data)
    );

    typedef struct packed {
        logic [1:0] dbits;
        logic [1:0] par;
        logic       flip;
        logic       stopv;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rx_ovr) ovr_seen++;
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input int nb, input logic [1:0] par,
                            input logic flip, input logic stopv);
        logic p;
        p = 1'b0;
        rx_drv = 1'b0;
        tick(16);
        for (int i = 0; i < nb; i++) begin
            rx_drv = d[i];
            p = p ^ d[i];
            tick(16);
        end
        if (par == 2'b01 || par == 2'b10) begin
            rx_drv = p ^ (par == 2'b10) ^ flip;
            tick(16);
        end
        rx_drv = stopv;
        tick(16);
        rx_drv = 1'b1;
        tick(4);
    endtask

    task automatic rx_accept(input string name);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check({name, "_valid_drop"}, rx_valid, 0);
    endtask

    task automatic tx_frame(input logic [7:0] d, output logic [10:0] cap, output int rlow);
        bit started;
        int pos;
        started = 0;
        pos = 0;
        rlow = 0;
        cap = '0;
        tx_data = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (tx_ready) break;
            rlow++;
            if (!started && uart_tx == 1'b0) started = 1;
            if (started) begin
                if (pos % 16 == 8 && pos / 16 < 11) cap[pos / 16] = uart_tx;
                pos++;
            end
            tick(1);
        end
    endtask

    initial begin
        logic [10:0] cap;
        int rlow, run, nb;
        bit saw_low;

        vecs[0] = '{2'd3, 2'd0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{2'd2, 2'd1, 1'b0, 1'b1, 8'h35, 8'h35, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 2'd1, 1'b1, 1'b1, 8'h35, 8'h35, 1'b1, 1'b0};
        vecs[3] = '{2'd3, 2'd0, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{2'd0, 2'd2, 1'b0, 1'b1, 8'h1B, 8'h1B, 1'b0, 1'b0};
        vecs[5] = '{2'd1, 2'd2, 1'b1, 1'b1, 8'h2A, 8'h2A, 1'b1, 1'b0};
        vecs[6] = '{2'd0, 2'd0, 1'b0, 1'b1, 8'hFF, 8'h1F, 1'b0, 1'b0};
        vecs[7] = '{2'd1, 2'd1, 1'b0, 1'b0, 8'h3F, 8'h3F, 1'b0, 1'b1};

        rst_ni = 1'b0; cfg_div = 16'd16; cfg_db = 2'd3; cfg_par = 2'd0; cfg_stop2 = 1'b0;
        rx_drv = 1'b1; loop_en = 1'b0; uart_rts = 1'b1; rx_ready = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        tick(3);
        check("rst_tx", uart_tx, 1);
        check("rst_cts", uart_cts, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_perr", rx_perr, 0);
        check("rst_ferr", rx_ferr, 0);
        check("rst_ovr", rx_ovr, 0);
        rst_ni = 1'b1;
        tick(3);

        // loopback 8N1 0xA5
        loop_en = 1'b1;
        tx_frame(8'hA5, cap, rlow);
        check("a5_line", cap[9:0], 10'h34A);
        check("a5_ready_low_len", (rlow >= 160 && rlow <= 161), 1);
        tick(4);
        check("a5_rx_valid", rx_valid, 1);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_rx_perr_ferr", {rx_perr, rx_ferr}, 0);
        rx_accept("a5");

        // loopback 7E1 0x35
        cfg_db = 2'd2; cfg_par = 2'd1;
        tx_frame(8'h35, cap, rlow);
        check("7e1_line", cap[9:0], 10'h26A);
        check("7e1_ready_low_len", (rlow >= 160 && rlow <= 161), 1);
        tick(4);
        check("7e1_rx_data", rx_data, 8'h35);
        check("7e1_rx_perr", rx_perr, 0);
        rx_accept("7e1");
        loop_en = 1'b0;

        // 0.25-bit glitch must not produce a word
        cfg_db = 2'd3; cfg_par = 2'd0;
        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(40);
        check("false_start_no_valid", rx_valid, 0);

        for (int i = 0; i < 8; i++) begin
            cfg_db = vecs[i].dbits;
            cfg_par = vecs[i].par;
            nb = int'(vecs[i].dbits) + 5;
            rx_frame(vecs[i].din, nb, vecs[i].par, vecs[i].flip, vecs[i].stopv);
            check($sformatf("vec%0d_valid", i), rx_valid, 1);
            check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_perr", i), rx_perr, vecs[i].exp_perr);
            check($sformatf("vec%0d_ferr", i), rx_ferr, vecs[i].exp_ferr);
            rx_accept($sformatf("vec%0d", i));
        end

        // overrun: second word dropped while first is held
        cfg_db = 2'd3; cfg_par = 2'd0;
        ovr_seen = 0;
        rx_frame(8'h11, 8, 2'd0, 1'b0, 1'b1);
        rx_frame(8'h22, 8, 2'd0, 1'b0, 1'b1);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held", rx_data, 8'h11);
        check("ovr_cts_low", uart_cts, 0);
        check("ovr_pulse_count", ovr_seen, 1);
        rx_accept("ovr");
        tick(40);
        check("ovr_word_lost", rx_valid, 0);
        check("ovr_no_extra_pulse", ovr_seen, 1);
        check("cts_back_high", uart_cts, 1);

        // flow control and two stop bits
        cfg_stop2 = 1'b1;
        uart_rts = 1'b0;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check("rts_word_accepted", tx_ready, 0);
        saw_low = 0;
        for (int i = 0; i < 50; i++) begin
            if (!uart_tx) saw_low = 1;
            tick(1);
        end
        check("rts_line_idle", saw_low, 0);
        uart_rts = 1'b1;
        tick(1);
        check("rts_start_next_clk", uart_tx, 0);
        uart_rts = 1'b0;
        run = 0;
        for (int n = 0; n < 400; n++) begin
            if (tx_ready) break;
            run = uart_tx ? run + 1 : 0;
            tick(1);
        end
        check("stop2_high_len", run, 32);
        check("stop2_ready", tx_ready, 1);
        cfg_stop2 = 1'b0;
        uart_rts = 1'b1;
        tick(4);

        // reset in the middle of data bit 3
        loop_en = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!uart_tx) break;
            tick(1);
        end
        tick(72);
        check("mid_bit3_line_low", uart_tx, 0);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_tx_line", uart_tx, 1);
        check("rst_mid_tx_ready", tx_ready, 1);
        tick(2);
        rst_ni = 1'b1;
        tick(3);
        tx_frame(8'hC3, cap, rlow);
        check("post_rst_line", cap[9:0], 10'h386);
        tick(4);
        check("post_rst_rx_data", rx_data, 8'hC3);
        check("post_rst_rx_valid", rx_valid, 1);
        rx_accept("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
